// File: rtl/char_tx_uart.sv
// char_tx_uart: FIFO-buffered 8N1 UART transmitter for the character port.
// CPU stores land in a circular FIFO; a four-state serialiser pops one byte
// at a time from IDLE and shifts it out LSB first. Status flags are
// registered alongside the FIFO count so they always agree with it.
module char_tx_uart #(
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       tx,
  output logic       full,
  output logic       empty,
  output logic       tx_busy,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          r_full;
  logic          r_empty;
  logic          r_overflow;

  state_t        r_state;
  state_t        w_state_next;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          w_tx_next;

  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_baud_done;

  // A pop only happens from IDLE with data already counted, so a byte
  // written into an empty FIFO is never popped in the same cycle.
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
  assign w_push      = wr_en && (!r_full || w_pop);
  assign w_drop      = wr_en && r_full && !w_pop;
  assign w_baud_done = (r_baud == BAUD_LAST);

  // Next FIFO occupancy from this cycle's push/pop pair.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // FIFO storage array; written only on an accepted push.
  // NOTE: the array is not reset; entries are only read behind a nonzero count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  // FIFO pointers, count, registered flags and sticky overflow.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == DEPTH_C);
      r_empty <= (w_count_next == '0);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Serialiser state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Serialiser next-state and line level for the current state.
  always_comb begin
    w_state_next = r_state;
    w_tx_next    = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_pop) w_state_next = S_START;
      end
      S_START: begin
        w_tx_next = 1'b0;
        if (w_baud_done) w_state_next = S_DATA;
      end
      S_DATA: begin
        w_tx_next = r_shift[0];
        if (w_baud_done && (r_bit_idx == 3'd7)) w_state_next = S_STOP;
      end
      S_STOP: begin
        if (w_baud_done) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Baud counter, bit index, shift register and registered tx line.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_tx <= w_tx_next;
      if (r_state == S_IDLE) begin
        r_baud    <= '0;
        r_bit_idx <= '0;
        if (w_pop) r_shift <= r_mem[r_rd_ptr];
      end else if (w_baud_done) begin
        r_baud <= '0;
        if (r_state == S_DATA) begin
          r_shift   <= r_shift >> 1;
          r_bit_idx <= r_bit_idx + 3'd1;
        end
      end else begin
        r_baud <= r_baud + BW'(1);
      end
    end
  end

  assign tx       = r_tx;
  assign full     = r_full;
  assign empty    = r_empty;
  assign overflow = r_overflow;
  assign tx_busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_char_tx_uart.sv
// tb_char_tx_uart: directed bench for char_tx_uart (CLKS_PER_BIT=4).
// Main instance uses DEPTH=4; a second DEPTH=2 instance covers pointer wrap.
// Edges are numbered by cyc; line levels are logged per edge on the falling
// clock and frames are checked cycle-by-cycle against hand-derived timing.
module tb_char_tx_uart;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       tx, full, empty, tx_busy, overflow;
  logic       wr_en2;
  logic [7:0] wr_data2;
  logic       tx2, full2, empty2, tx_busy2, overflow2;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  logic log_tx   [4096];
  logic log_busy [4096];
  logic log_empty[4096];
  logic log_ovf  [4096];
  logic log_tx2  [4096];

  always #5 clk = ~clk;

  char_tx_uart #(.DEPTH(4), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .tx(tx), .full(full), .empty(empty), .tx_busy(tx_busy), .overflow(overflow)
  );

  char_tx_uart #(.DEPTH(2), .CLKS_PER_BIT(4)) dut2 (
    .clk(clk), .reset(reset), .wr_en(wr_en2), .wr_data(wr_data2),
    .tx(tx2), .full(full2), .empty(empty2), .tx_busy(tx_busy2), .overflow(overflow2)
  );

  // Edge counter: after rising edge E, cyc == E.
  always @(posedge clk) cyc <= cyc + 1;

  // Per-edge log of outputs, sampled on the falling clock.
  always @(negedge clk) begin
    if (cyc < 4096) begin
      log_tx[cyc]    <= tx;
      log_busy[cyc]  <= tx_busy;
      log_empty[cyc] <= empty;
      log_ovf[cyc]   <= overflow;
      log_tx2[cyc]   <= tx2;
    end
  end

  // Expected line level at offset o from the first start-bit cycle.
  function automatic logic frame_bit(input logic [7:0] b, input int o);
    if (o < 0)  return 1'b1;
    if (o < 4)  return 1'b0;
    if (o < 36) return b[(o - 4) / 4];
    return 1'b1;
  endfunction

  // Number of logged cycles around a frame that differ from the ideal frame.
  function automatic int frame_errs(input int s, input logic [7:0] b);
    int e = 0;
    for (int o = -1; o <= 40; o++)
      if (log_tx[s + o] !== frame_bit(b, o)) e++;
    return e;
  endfunction

  // Mid-bit sampling receiver over a logged line.
  function automatic logic [7:0] decode(input int s, input bit second);
    logic [7:0] d;
    for (int i = 0; i < 8; i++)
      d[i] = second ? log_tx2[s + 6 + 4 * i] : log_tx[s + 6 + 4 * i];
    return d;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; wr_en = 1'b0; wr_data = 'x; wr_en2 = 1'b0; wr_data2 = 'x;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (tx !== 1'b1)       $display("FAIL reset_tx: got %b want 1", tx);             else n_pass++;
    n_total++; if (full !== 1'b0)     $display("FAIL reset_full: got %b want 0", full);         else n_pass++;
    n_total++; if (empty !== 1'b1)    $display("FAIL reset_empty: got %b want 1", empty);       else n_pass++;
    n_total++; if (tx_busy !== 1'b0)  $display("FAIL reset_busy: got %b want 0", tx_busy);      else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else n_pass++;
  endtask

  task automatic test_single();
    int n, first_low, busy_cnt, e;
    logic [7:0] got;
    @(negedge clk); wr_en = 1'b1; wr_data = 8'h41; n = cyc + 1;
    @(negedge clk); wr_en = 1'b0; wr_data = 'x;
    n_total++; if (empty !== 1'b0) $display("FAIL single_empty_after_write: got %b want 0", empty); else n_pass++;
    tick(50);
    first_low = -1;
    for (int k = n; k <= n + 10; k++)
      if (first_low < 0 && log_tx[k] === 1'b0) first_low = k;
    n_total++; if (first_low !== n + 2) $display("FAIL single_latency: got edge %0d want %0d", first_low, n + 2); else n_pass++;
    e = frame_errs(n + 2, 8'h41);
    n_total++; if (e !== 0) $display("FAIL single_waveform: got %0d bad cycles want 0", e); else n_pass++;
    got = decode(n + 2, 1'b0);
    n_total++; if (got !== 8'h41) $display("FAIL single_byte: got %h want 41", got); else n_pass++;
    busy_cnt = 0;
    for (int k = n; k <= n + 50; k++) if (log_busy[k] === 1'b1) busy_cnt++;
    n_total++; if (busy_cnt !== 40) $display("FAIL single_busy_len: got %0d want 40", busy_cnt); else n_pass++;
    n_total++; if (log_busy[n + 41] !== 1'b0) $display("FAIL single_idle_after: got %b want 0", log_busy[n + 41]); else n_pass++;
    n_total++; if (log_empty[n + 1] !== 1'b1) $display("FAIL single_empty_after_pop: got %b want 1", log_empty[n + 1]); else n_pass++;
  endtask

  task automatic test_burst();
    logic [7:0] d [3] = '{8'h55, 8'hAA, 8'h0F};
    int n, e, gap;
    logic [7:0] got;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); wr_en = 1'b1; wr_data = d[i];
      if (i == 0) n = cyc + 1;
    end
    @(negedge clk); wr_en = 1'b0; wr_data = 'x;
    tick(41 * 3 + 10);
    for (int f = 0; f < 3; f++) begin
      e = frame_errs(n + 2 + 41 * f, d[f]);
      n_total++; if (e !== 0) $display("FAIL burst_waveform_%0d: got %0d bad cycles want 0", f, e); else n_pass++;
      got = decode(n + 2 + 41 * f, 1'b0);
      n_total++; if (got !== d[f]) $display("FAIL burst_byte_%0d: got %h want %h", f, got, d[f]); else n_pass++;
    end
    gap = 0;
    for (int k = n + 38; k < n + 58; k++) begin
      if (log_tx[k] !== 1'b1) break;
      gap++;
    end
    n_total++; if (gap !== 5) $display("FAIL burst_gap: got %0d high cycles want 5", gap); else n_pass++;
    n_total++; if (log_empty[n + 82] !== 1'b0) $display("FAIL burst_empty_before_last_pop: got %b want 0", log_empty[n + 82]); else n_pass++;
    n_total++; if (log_empty[n + 83] !== 1'b1) $display("FAIL burst_empty_after_last_pop: got %b want 1", log_empty[n + 83]); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [7:0] d [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    int n, lows;
    logic [7:0] got;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); wr_en = 1'b1; wr_data = d[i];
      if (i == 0) n = cyc + 1;
    end
    @(negedge clk); wr_en = 1'b0; wr_data = 'x;
    n_total++; if (full !== 1'b1)     $display("FAIL ovf_full: got %b want 1", full);         else n_pass++;
    n_total++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow);     else n_pass++;
    n_total++; if (log_ovf[n + 4] !== 1'b0) $display("FAIL ovf_early: got %b want 0", log_ovf[n + 4]); else n_pass++;
    tick(41 * 5 + 60);
    for (int f = 0; f < 5; f++) begin
      got = decode(n + 2 + 41 * f, 1'b0);
      n_total++; if (got !== d[f]) $display("FAIL ovf_byte_%0d: got %h want %h", f, got, d[f]); else n_pass++;
    end
    lows = 0;
    for (int k = n + 206; k <= n + 256; k++) if (log_tx[k] !== 1'b1) lows++;
    n_total++; if (lows !== 0) $display("FAIL ovf_no_sixth_frame: got %0d low cycles want 0", lows); else n_pass++;
    n_total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else n_pass++;
  endtask

  task automatic test_full_pop();
    logic [7:0] d [5] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
    int n, t_idle, e;
    logic [7:0] got;
    do_reset();
    n_total++; if (overflow !== 1'b0) $display("FAIL fullpop_reset_clears_ovf: got %b want 0", overflow); else n_pass++;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); wr_en = 1'b1; wr_data = d[i];
      if (i == 0) n = cyc + 1;
    end
    @(negedge clk); wr_en = 1'b0; wr_data = 'x;
    t_idle = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (tx_busy === 1'b0) begin t_idle = cyc; break; end
    end
    n_total++; if (t_idle !== n + 41) $display("FAIL fullpop_idle_edge: got %0d want %0d", t_idle, n + 41); else n_pass++;
    wr_en = 1'b1; wr_data = 8'h77;
    @(negedge clk); wr_en = 1'b0; wr_data = 'x;
    n_total++; if (full !== 1'b1)     $display("FAIL fullpop_full: got %b want 1", full);     else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL fullpop_ovf: got %b want 0", overflow);  else n_pass++;
    n_total++; if (tx_busy !== 1'b1)  $display("FAIL fullpop_busy: got %b want 1", tx_busy);  else n_pass++;
    tick(215);
    got = decode(n + 2 + 41 * 4, 1'b0);
    n_total++; if (got !== 8'hC5) $display("FAIL fullpop_byte_4: got %h want c5", got); else n_pass++;
    e = frame_errs(n + 2 + 41 * 5, 8'h77);
    n_total++; if (e !== 0) $display("FAIL fullpop_last_waveform: got %0d bad cycles want 0", e); else n_pass++;
  endtask

  task automatic test_midreset();
    int n, lows;
    n = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); wr_en = 1'b1; wr_data = 8'h41 + 8'(i);
      if (i == 0) n = cyc + 1;
    end
    @(negedge clk); wr_en = 1'b0; wr_data = 'x;
    tick(15);
    n_total++; if (tx !== 1'b0)      $display("FAIL midrst_pre_tx: got %b want 0", tx);        else n_pass++;
    n_total++; if (empty !== 1'b0)   $display("FAIL midrst_pre_empty: got %b want 0", empty);  else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_total++; if (tx !== 1'b1)      $display("FAIL midrst_tx: got %b want 1", tx);            else n_pass++;
    n_total++; if (empty !== 1'b1)   $display("FAIL midrst_empty: got %b want 1", empty);      else n_pass++;
    n_total++; if (tx_busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", tx_busy);    else n_pass++;
    tick(100);
    lows = 0;
    for (int k = n + 18; k <= n + 110; k++) if (log_tx[k] !== 1'b1) lows++;
    n_total++; if (lows !== 0) $display("FAIL midrst_no_more_frames: got %0d low cycles want 0", lows); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [7:0] d [10] = '{8'h00, 8'hFF, 8'h81, 8'h7E, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    int idx, t0, p, s;
    logic [7:0] got;
    idx = 0;
    t0  = cyc;
    for (int k = 0; k < 1500 && idx < 10; k++) begin
      @(negedge clk);
      if (full2 === 1'b0) begin
        wr_en2 = 1'b1; wr_data2 = d[idx]; idx++;
      end else begin
        wr_en2 = 1'b0; wr_data2 = 'x;
      end
    end
    @(negedge clk); wr_en2 = 1'b0; wr_data2 = 'x;
    n_total++; if (idx !== 10) $display("FAIL wrap_all_written: got %0d want 10", idx); else n_pass++;
    tick(150);
    p = t0;
    for (int f = 0; f < 10; f++) begin
      s = -1;
      for (int k = p; k < p + 100; k++)
        if (log_tx2[k] === 1'b0) begin s = k; break; end
      got = (s < 0) ? 8'hxx : decode(s, 1'b1);
      n_total++; if (got !== d[f]) $display("FAIL wrap_byte_%0d: got %h want %h", f, got, d[f]); else n_pass++;
      p = (s < 0) ? p + 41 : s + 40;
    end
    n_total++; if (overflow2 !== 1'b0) $display("FAIL wrap_no_overflow: got %b want 0", overflow2); else n_pass++;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = 'x; wr_en2 = 1'b0; wr_data2 = 'x;
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_full_pop();
    test_midreset();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
